// File: rtl/egress_frame_fifo.sv
// Egress frame FIFO: VLAN-filtered, store-and-forward frame buffer in front of a MAC.
// Frames are committed whole; dropped or reset-cut frames never reach tx_*.
module egress_frame_fifo #(
  parameter int DEPTH     = 512,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [3:0]               in_bytes_valid,
  input  logic [63:0]              in_data,
  input  logic [11:0]              in_vlan,
  input  logic [11:0]              cfg_vlan,
  input  logic                     cfg_trunk,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [63:0]              tx_data,
  output logic [3:0]               tx_bytes_valid,
  output logic                     tx_last,
  output logic [$clog2(DEPTH):0]   free_words,
  output logic [CNT_WIDTH-1:0]     drop_vlan_count,
  output logic [CNT_WIDTH-1:0]     drop_ovf_count
);

  localparam int DATA_W = 64;
  localparam int AW     = $clog2(DEPTH);
  localparam int WORD_W = DATA_W + 5;

  typedef logic [AW:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCEPT, DROP, WAIT_IDLE} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t state, state_nxt;
  ptr_t   wr_ptr, commit_ptr, rd_ptr, fetch_ptr, fetch_nxt, used;
  logic   drop_ovf_q, drop_ovf_nxt;
  logic   wr_en, wr_last, hold_load, commit_en, rewind, inc_vlan, inc_ovf;
  logic   room_one, room_two, vlan_ok, load;

  // Word held one cycle so the last word can be tagged once in_valid falls
  logic signed [DATA_W-1:0] hold_data_p0;
  logic [3:0]               hold_bytes_p0;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] ram_q_p1;
  logic              ram_ok_p1;

  // Space check counts the held word: one slot to start a frame, two to keep going
  assign used     = wr_ptr - rd_ptr;
  assign room_one = used < DEPTH_P;
  assign room_two = used < (DEPTH_P - ptr_t'(1));
  assign vlan_ok  = cfg_trunk || (in_vlan == cfg_vlan);

  // Ingress FSM state register and drop cause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_IDLE;
      drop_ovf_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop_ovf_q <= drop_ovf_nxt;
    end
  end

  // Ingress next-state and write/commit/drop controls
  always_comb begin
    state_nxt    = state;
    drop_ovf_nxt = drop_ovf_q;
    wr_en        = 1'b0;
    wr_last      = 1'b0;
    hold_load    = 1'b0;
    commit_en    = 1'b0;
    rewind       = 1'b0;
    inc_vlan     = 1'b0;
    inc_ovf      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (!vlan_ok) begin
            state_nxt    = DROP;
            drop_ovf_nxt = 1'b0;
          end else if (!room_one) begin
            state_nxt    = DROP;
            drop_ovf_nxt = 1'b1;
          end else begin
            hold_load = 1'b1;
            state_nxt = ACCEPT;
          end
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          if (room_two) begin
            wr_en     = 1'b1;
            hold_load = 1'b1;
          end else begin
            state_nxt    = DROP;
            drop_ovf_nxt = 1'b1;
          end
        end else begin
          wr_en     = 1'b1;
          wr_last   = 1'b1;
          commit_en = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (!in_valid) begin
          rewind    = 1'b1;
          inc_vlan  = !drop_ovf_q;
          inc_ovf   = drop_ovf_q;
          state_nxt = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!in_valid) state_nxt = IDLE;
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  // Write-side pointers and drop counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      drop_vlan_count <= '0;
      drop_ovf_count  <= '0;
    end else begin
      if (rewind)     wr_ptr <= commit_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + ptr_t'(1);
      if (commit_en)  commit_ptr <= wr_ptr + ptr_t'(1);
      if (inc_vlan)   drop_vlan_count <= sat_inc(drop_vlan_count);
      if (inc_ovf)    drop_ovf_count  <= sat_inc(drop_ovf_count);
    end
  end

  // ---- stage p0: hold register for the word awaiting its last flag ----
  always_ff @(posedge clk) begin
    if (hold_load) begin
      hold_data_p0  <= in_data;
      hold_bytes_p0 <= in_bytes_valid;
    end
  end

  // ---- stage p1: RAM write and 1-cycle synchronous read at the next fetch address ----
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= {wr_last, (wr_last ? hold_bytes_p0 : 4'd8), hold_data_p0};
    ram_q_p1 <= mem[fetch_nxt[AW-1:0]];
  end

  // Output register loads when the RAM word is committed and the slot is free
  assign load      = ram_ok_p1 && (!tx_valid || tx_ready);
  assign fetch_nxt = load ? fetch_ptr + ptr_t'(1) : fetch_ptr;

  // Egress pointers, read-valid tracking and the tx output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_ptr      <= '0;
      rd_ptr         <= '0;
      ram_ok_p1      <= 1'b0;
      tx_valid       <= 1'b0;
      tx_last        <= 1'b0;
      tx_bytes_valid <= '0;
      tx_data        <= '0;
    end else begin
      fetch_ptr <= fetch_nxt;
      ram_ok_p1 <= (fetch_nxt != commit_ptr);
      if (tx_valid && tx_ready) rd_ptr <= rd_ptr + ptr_t'(1);
      if (load) begin
        tx_valid       <= 1'b1;
        tx_last        <= ram_q_p1[WORD_W-1];
        tx_bytes_valid <= ram_q_p1[DATA_W +: 4];
        tx_data        <= ram_q_p1[DATA_W-1:0];
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

  // Registered free space against consumed words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) free_words <= DEPTH_P;
    else     free_words <= DEPTH_P - used;
  end

endmodule

// File: tb/tb_egress_frame_fifo.sv
// Directed testbench for egress_frame_fifo (DEPTH=16, CNT_WIDTH=4).
module tb_egress_frame_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [3:0]    in_bytes_valid = 4'd0;
  logic [63:0]   in_data = '0;
  logic [11:0]   in_vlan = '0;
  logic [11:0]   cfg_vlan = 12'd10;
  logic          cfg_trunk = 1'b0;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [63:0]   tx_data;
  logic [3:0]    tx_bytes_valid;
  logic          tx_last;
  logic [4:0]    free_words;
  logic [CW-1:0] drop_vlan_count;
  logic [CW-1:0] drop_ovf_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [68:0] got_q[$];
  logic [68:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [68:0] prev_word  = '0;

  egress_frame_fifo #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bytes_valid(in_bytes_valid),
    .in_data(in_data), .in_vlan(in_vlan), .cfg_vlan(cfg_vlan), .cfg_trunk(cfg_trunk),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_bytes_valid(tx_bytes_valid), .tx_last(tx_last), .free_words(free_words),
    .drop_vlan_count(drop_vlan_count), .drop_ovf_count(drop_ovf_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Collect accepted words and check that a stalled output holds still
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (!tx_valid || {tx_last, tx_bytes_valid, tx_data} !== prev_word) begin
          n_fail++;
          $display("FAIL stall_hold got v=%0b %h exp v=1 %h", tx_valid,
                   {tx_last, tx_bytes_valid, tx_data}, prev_word);
        end
      end
      if (tx_valid && tx_ready) got_q.push_back({tx_last, tx_bytes_valid, tx_data});
      prev_stall = tx_valid && !tx_ready;
      prev_word  = {tx_last, tx_bytes_valid, tx_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [68:0] exp_word(int base, int i, int n, int lb);
    logic [63:0] d;
    logic [3:0]  b;
    logic        l;
    d = {base[31:0], i[31:0]};
    l = (i == n - 1);
    b = l ? lb[3:0] : 4'd8;
    return {l, b, d};
  endfunction

  task automatic send_frame(int n, int vlan, int base, int lb);
    for (int i = 0; i < n; i++) begin
      in_valid       = 1'b1;
      in_vlan        = vlan[11:0];
      in_data        = {base[31:0], i[31:0]};
      in_bytes_valid = (i == n - 1) ? lb[3:0] : 4'd8;
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic expect_frame(int n, int base, int lb);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_word(base, i, n, lb));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 64'd0 || tx_bytes_valid !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_tx got v=%0b l=%0b d=%h b=%0d exp all zero", tx_valid, tx_last, tx_data, tx_bytes_valid);
    end
    n_checks++;
    if (drop_vlan_count !== 4'd0 || drop_ovf_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_counters got %0d/%0d exp 0/0", drop_vlan_count, drop_ovf_count);
    end
    n_checks++;
    if (free_words !== 5'd16) begin
      n_fail++;
      $display("FAIL reset_free got %0d exp 16", free_words);
    end
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_accept();
    got_q.delete(); exp_q.delete();
    cfg_trunk = 1'b0; cfg_vlan = 12'd10; tx_ready = 1'b1;
    send_frame(8, 10, 32'h1000, 3);
    expect_frame(8, 32'h1000, 3);
    repeat (20) tick();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL accept_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL accept_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (free_words !== 5'd16) begin
      n_fail++;
      $display("FAIL accept_free got %0d exp 16", free_words);
    end
  endtask

  task automatic test_vlan_filter();
    got_q.delete(); exp_q.delete();
    send_frame(8, 20, 32'h2000, 5);
    repeat (20) tick();
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL vlan_drop_out got %0d words exp 0", got_q.size());
    end
    n_checks++;
    if (drop_vlan_count !== 4'd1) begin
      n_fail++;
      $display("FAIL vlan_drop_count got %0d exp 1", drop_vlan_count);
    end
    n_checks++;
    if (free_words !== 5'd16) begin
      n_fail++;
      $display("FAIL vlan_drop_free got %0d exp 16", free_words);
    end
    cfg_trunk = 1'b1;
    send_frame(8, 20, 32'h2100, 5);
    expect_frame(8, 32'h2100, 5);
    cfg_trunk = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL trunk_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL trunk_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    got_q.delete(); exp_q.delete();
    tx_ready = 1'b0;
    send_frame(10, 10, 32'h3000, 8);
    send_frame(10, 10, 32'h3100, 8);
    expect_frame(10, 32'h3000, 8);
    repeat (5) tick();
    n_checks++;
    if (drop_ovf_count !== 4'd1) begin
      n_fail++;
      $display("FAIL ovf_count got %0d exp 1", drop_ovf_count);
    end
    n_checks++;
    if (free_words !== 5'd6) begin
      n_fail++;
      $display("FAIL ovf_free got %0d exp 6", free_words);
    end
    n_checks++;
    if (tx_valid !== 1'b1 || {tx_last, tx_bytes_valid, tx_data} !== exp_q[0]) begin
      n_fail++;
      $display("FAIL ovf_stalled_head got v=%0b %h exp v=1 %h", tx_valid,
               {tx_last, tx_bytes_valid, tx_data}, exp_q[0]);
    end
    tx_ready = 1'b1;
    repeat (30) tick();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL ovf_drain_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL ovf_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (free_words !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_free_end got %0d exp 16", free_words);
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete(); exp_q.delete();
    expect_frame(3, 32'h4000, 2);
    expect_frame(5, 32'h4100, 7);
    expect_frame(1, 32'h4200, 1);
    expect_frame(4, 32'h4300, 6);
    fork
      begin
        send_frame(3, 10, 32'h4000, 2);
        send_frame(5, 10, 32'h4100, 7);
        send_frame(1, 10, 32'h4200, 1);
        send_frame(4, 10, 32'h4300, 6);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          tx_ready = ($urandom_range(0, 1) == 1);
          tick();
        end
      end
    join
    tx_ready = 1'b1;
    repeat (30) tick();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    got_q.delete(); exp_q.delete();
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid       = 1'b1;
      in_vlan        = 12'd10;
      in_data        = {32'h5000, i[31:0]};
      in_bytes_valid = (i == 5) ? 4'd4 : 4'd8;
      if (i == 2) rst = 1'b1;
      if (i == 4) rst = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstcut_out got %0d words exp 0", got_q.size());
    end
    n_checks++;
    if (drop_vlan_count !== 4'd0 || drop_ovf_count !== 4'd0) begin
      n_fail++;
      $display("FAIL rstcut_counters got %0d/%0d exp 0/0", drop_vlan_count, drop_ovf_count);
    end
    n_checks++;
    if (free_words !== 5'd16) begin
      n_fail++;
      $display("FAIL rstcut_free got %0d exp 16", free_words);
    end
    send_frame(4, 10, 32'h5100, 6);
    expect_frame(4, 32'h5100, 6);
    repeat (20) tick();
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rstcut_next_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rstcut_next_word%0d got %h exp %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    cfg_trunk = 1'b0;
    for (int k = 0; k < 16; k++) send_frame(1, 99, 32'h6000 + k, 1);
    tick();
    n_checks++;
    if (drop_vlan_count !== 4'hF) begin
      n_fail++;
      $display("FAIL sat_preload got %0d exp 15", drop_vlan_count);
    end
    send_frame(2, 99, 32'h6100, 1);
    tick();
    n_checks++;
    if (drop_vlan_count !== 4'hF) begin
      n_fail++;
      $display("FAIL sat_hold got %0d exp 15", drop_vlan_count);
    end
    n_checks++;
    if (drop_ovf_count !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_ovf_untouched got %0d exp 0", drop_ovf_count);
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_vlan_filter();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
